control_word_executor: RTL

Consumes the 55-bit ALU control word produced by the instruction decoders and carries it out against the register file, the external ALU, and the memory and stack ports. It reads operands, captures the ALU result, and performs the load or store handshake. It then writes back and pulses the program-counter increment. It is the datapath-side counterpart of the control word encoder and decoder pair, sitting between the instruction decode stage and the memory/stack subsystem.

---
 rtl/control_word_pkg.sv | 65 ++++++
 rtl/register_file_16x16.sv | 36 +++
 rtl/control_word_executor.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/control_word_pkg.sv
`default_nettype none
// ============================================================================
// control_word_pkg
// Shared field layout, load-source codes and FSM encoding for the 55-bit
// ALU control word consumed by control_word_executor.
// Revision: 1.0
// ============================================================================
package control_word_pkg;

    localparam int CW_WIDTH      = 55;
    localparam int DATA_W        = 16;
    localparam int SEL_W         = 4;
    localparam int ALU_OP_W      = 4;
    localparam int LOAD_SRC_W    = 2;

    localparam int PC_INC_BIT    = 54;
    localparam int ALU_OP_LSB    = 50;
    localparam int A_ALTERN_LSB  = 34;
    localparam int B_ALTERN_LSB  = 18;
    localparam int A_SEL_LSB     = 14;
    localparam int B_SEL_LSB     = 10;
    localparam int A_SRC_BIT     = 9;
    localparam int B_SRC_BIT     = 8;
    localparam int OUT_SEL_LSB   = 4;
    localparam int LOAD_SRC_LSB  = 2;
    localparam int STORE_MEM_BIT = 1;
    localparam int STORE_STK_BIT = 0;

    localparam logic [LOAD_SRC_W-1:0] LOAD_NONE = 2'b00;
    localparam logic [LOAD_SRC_W-1:0] LOAD_ALU  = 2'b01;
    localparam logic [LOAD_SRC_W-1:0] LOAD_MEM  = 2'b10;
    localparam logic [LOAD_SRC_W-1:0] LOAD_STK  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_EXEC   = 2'd1,
        ST_ACCESS = 2'd2,
        ST_DONE   = 2'd3
    } exec_state_e;

    typedef struct packed {
        logic                  pc_inc;
        logic [ALU_OP_W-1:0]   alu_op;
        logic [DATA_W-1:0]     a_altern;
        logic [DATA_W-1:0]     b_altern;
        logic [SEL_W-1:0]      a_sel;
        logic [SEL_W-1:0]      b_sel;
        logic                  a_src;
        logic                  b_src;
        logic [SEL_W-1:0]      out_sel;
        logic [LOAD_SRC_W-1:0] load_src;
        logic                  store_mem;
        logic                  store_stk;
    } control_word_t;

    // A word may touch at most one port: store_mem, store_stk and a port load
    // are mutually exclusive.
    function automatic logic cw_is_illegal(input control_word_t cw);
        logic [1:0] n_access;
        n_access = {1'b0, cw.store_mem} + {1'b0, cw.store_stk} + {1'b0, cw.load_src[1]};
        return (n_access > 2'd1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/register_file_16x16.sv
`default_nettype none
// ============================================================================
// register_file_16x16
// Sixteen 16-bit general-purpose registers: two async read ports, one sync
// write port, asynchronous active-high reset.
// Revision: 1.0
// ============================================================================
module register_file_16x16 (
    input  logic        clock,
    input  logic        reset,
    input  logic [3:0]  rd_a_addr_i,
    output logic [15:0] rd_a_data_o,
    input  logic [3:0]  rd_b_addr_i,
    output logic [15:0] rd_b_data_o,
    input  logic        wr_en_i,
    input  logic [3:0]  wr_addr_i,
    input  logic [15:0] wr_data_i
);

    logic [15:0] regs_q [16];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 16; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wr_en_i) begin
            regs_q[wr_addr_i] <= wr_data_i;
        end
    end

    assign rd_a_data_o = regs_q[rd_a_addr_i];
    assign rd_b_data_o = regs_q[rd_b_addr_i];

endmodule
`default_nettype wire

// File: rtl/control_word_executor.sv
`default_nettype none
// ============================================================================
// control_word_executor
// Executes decoded 55-bit control words against the register file, external
// ALU and memory/stack ports. Optional ACCESS timeout: CONTROL_WORD_EXECUTOR_TIMEOUT_EN.
// Revision: 1.0
// ============================================================================
module control_word_executor
    import control_word_pkg::*;
(
    input  logic                clock,
    input  logic                reset,
    input  logic [CW_WIDTH-1:0] control_word,
    input  logic                control_word_valid,
    output logic                control_word_ready,
    output logic [DATA_W-1:0]   alu_a,
    output logic [DATA_W-1:0]   alu_b,
    output logic [ALU_OP_W-1:0] alu_op,
    input  logic [DATA_W-1:0]   alu_result,
    output logic                mem_req,
    output logic                mem_we,
    output logic [DATA_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic [DATA_W-1:0]   mem_rdata,
    input  logic                mem_ack,
    output logic                stk_req,
    output logic                stk_we,
    output logic [DATA_W-1:0]   stk_addr,
    output logic [DATA_W-1:0]   stk_wdata,
    input  logic [DATA_W-1:0]   stk_rdata,
    input  logic                stk_ack,
    output logic                program_counter_increment,
    output logic                busy,
    output logic                error
);

    exec_state_e         state_q, state_d;
    control_word_t       word_q, word_d;
    control_word_t       cw_in;
    logic [DATA_W-1:0]   store_addr_q, store_addr_d;
    logic [DATA_W-1:0]   port_addr_q, port_addr_d;
    logic [DATA_W-1:0]   port_wdata_q, port_wdata_d;
    logic                mem_req_q, mem_req_d, mem_we_q, mem_we_d;
    logic                stk_req_q, stk_req_d, stk_we_q, stk_we_d;
    logic                error_q, error_d;

    logic [SEL_W-1:0]    rd_a_addr;
    logic [DATA_W-1:0]   rd_a_data, rd_b_data;
    logic                wr_en;
    logic [DATA_W-1:0]   wr_data;
    logic                is_exec, access_ack, word_illegal, needs_access;

`ifdef CONTROL_WORD_EXECUTOR_TIMEOUT_EN
    localparam logic [7:0] TIMEOUT_LAST = 8'd254;
    logic [7:0] tmo_cnt_q, tmo_cnt_d;
`endif

    assign cw_in = control_word;

    // In IDLE port A looks up R[out_sel] of the incoming word; nothing writes
    // the file between acceptance and EXEC, so this equals the EXEC-time value
    // and frees both ports for operands during EXEC.
    assign rd_a_addr = (state_q == ST_IDLE) ? cw_in.out_sel : word_q.a_sel;

    register_file_16x16 u_regfile (
        .clock       (clock),
        .reset       (reset),
        .rd_a_addr_i (rd_a_addr),
        .rd_a_data_o (rd_a_data),
        .rd_b_addr_i (word_q.b_sel),
        .rd_b_data_o (rd_b_data),
        .wr_en_i     (wr_en),
        .wr_addr_i   (word_q.out_sel),
        .wr_data_i   (wr_data)
    );

    assign is_exec      = (state_q == ST_EXEC);
    assign word_illegal = cw_is_illegal(word_q);
    assign needs_access = word_q.store_mem | word_q.store_stk | word_q.load_src[1];
    assign access_ack   = (mem_req_q & mem_ack) | (stk_req_q & stk_ack);

    assign alu_a  = is_exec ? (word_q.a_src ? word_q.a_altern : rd_a_data) : '0;
    assign alu_b  = is_exec ? (word_q.b_src ? word_q.b_altern : rd_b_data) : '0;
    assign alu_op = is_exec ? word_q.alu_op : '0;

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_req_q ? port_addr_q  : '0;
    assign mem_wdata = mem_req_q ? port_wdata_q : '0;
    assign stk_req   = stk_req_q;
    assign stk_we    = stk_we_q;
    assign stk_addr  = stk_req_q ? port_addr_q  : '0;
    assign stk_wdata = stk_req_q ? port_wdata_q : '0;

    assign control_word_ready        = (state_q == ST_IDLE);
    assign busy                      = (state_q != ST_IDLE);
    assign program_counter_increment = (state_q == ST_DONE) && word_q.pc_inc;
    assign error                     = error_q;

    always_comb begin
        state_d      = state_q;
        word_d       = word_q;
        store_addr_d = store_addr_q;
        port_addr_d  = port_addr_q;
        port_wdata_d = port_wdata_q;
        mem_req_d    = mem_req_q;
        mem_we_d     = mem_we_q;
        stk_req_d    = stk_req_q;
        stk_we_d     = stk_we_q;
        error_d      = error_q;
        wr_en        = 1'b0;
        wr_data      = alu_result;
`ifdef CONTROL_WORD_EXECUTOR_TIMEOUT_EN
        tmo_cnt_d    = tmo_cnt_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (control_word_valid) begin
                    word_d       = cw_in;
                    store_addr_d = rd_a_data;
                    state_d      = ST_EXEC;
                end
            end
            ST_EXEC: begin
`ifdef CONTROL_WORD_EXECUTOR_TIMEOUT_EN
                tmo_cnt_d = '0;
`endif
                if (word_illegal) begin
                    error_d = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    wr_en = (word_q.load_src == LOAD_ALU);
                    if (word_q.store_mem || word_q.store_stk) begin
                        port_addr_d  = store_addr_q;
                        port_wdata_d = alu_result;
                    end else begin
                        port_addr_d  = alu_result;
                        port_wdata_d = '0;
                    end
                    mem_req_d = word_q.store_mem || (word_q.load_src == LOAD_MEM);
                    mem_we_d  = word_q.store_mem;
                    stk_req_d = word_q.store_stk || (word_q.load_src == LOAD_STK);
                    stk_we_d  = word_q.store_stk;
                    state_d   = needs_access ? ST_ACCESS : ST_DONE;
                end
            end
            ST_ACCESS: begin
                if (access_ack) begin
                    wr_en        = word_q.load_src[1];
                    wr_data      = mem_req_q ? mem_rdata : stk_rdata;
                    mem_req_d    = 1'b0;
                    mem_we_d     = 1'b0;
                    stk_req_d    = 1'b0;
                    stk_we_d     = 1'b0;
                    port_addr_d  = '0;
                    port_wdata_d = '0;
                    state_d      = ST_DONE;
                end
`ifdef CONTROL_WORD_EXECUTOR_TIMEOUT_EN
                else if (tmo_cnt_q == TIMEOUT_LAST) begin
                    mem_req_d    = 1'b0;
                    mem_we_d     = 1'b0;
                    stk_req_d    = 1'b0;
                    stk_we_d     = 1'b0;
                    port_addr_d  = '0;
                    port_wdata_d = '0;
                    error_d      = 1'b1;
                    state_d      = ST_DONE;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 8'd1;
                end
`endif
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            word_q       <= '0;
            store_addr_q <= '0;
            port_addr_q  <= '0;
            port_wdata_q <= '0;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            stk_req_q    <= 1'b0;
            stk_we_q     <= 1'b0;
            error_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            word_q       <= word_d;
            store_addr_q <= store_addr_d;
            port_addr_q  <= port_addr_d;
            port_wdata_q <= port_wdata_d;
            mem_req_q    <= mem_req_d;
            mem_we_q     <= mem_we_d;
            stk_req_q    <= stk_req_d;
            stk_we_q     <= stk_we_d;
            error_q      <= error_d;
        end
    end

`ifdef CONTROL_WORD_EXECUTOR_TIMEOUT_EN
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            tmo_cnt_q <= '0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
        end
    end
`endif

endmodule
`default_nettype wire
